pla_fsm: RTL and testbench
==========================

Name: pla_fsm

Overview:
- Field-programmable finite state machine built from a sum-of-products plane.
- Each next-state bit and each output bit is the OR of N_TERMS product terms. Each term is an AND of selectable, optionally inverted literals taken from the primary inputs and the current state.
- The plane is loaded through a serial configuration chain. Chains of several units can be daisy-chained through cfg_out.
- It is the generalised, registered successor to the fixed three-term AND-OR cell used in earlier FSM tiles.

Parameters:
- N_IN, 2, number of primary inputs.
- N_STATE, 2, number of state register bits.
- N_OUT, 2, number of output bits.
- N_TERMS, 3, product terms per sum bit.
- OUT_REG, 0: 0 = Mealy outputs (combinational from inputs and state); 1 = outputs registered on the same edge as the state.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; state advances only when high.
- in  input  N_IN  primary inputs.
- cfg_en  input  1  configuration shift enable.
- cfg_data  input  1  serial configuration bit in.
- cfg_out  output  1  serial configuration bit out, for chaining.
- state  output  N_STATE  current state register.
- out  output  N_OUT  machine outputs.

Behaviour:
- Reset: rst_n low asynchronously clears cfg_sr (all CFG_W bits), state and out_q to 0. cfg_out is 0. With an all-zero plane, out is 0.
- Derived widths:
  - N_LIT = N_IN+N_STATE.
  - N_SUM = N_STATE+N_OUT.
  - CFG_W = N_SUM*N_TERMS*N_LIT*2. Default CFG_W = 96.
- Literal vector: lit[l] = in[l] for l<N_IN; lit[l] = state[l-N_IN] otherwise.
- Configuration field for sum s, term t, literal l: base = ((s*N_TERMS+t)*N_LIT+l)*2.
  - cfg_sr[base] = use.
  - cfg_sr[base+1] = pol (1 = complemented).
- Sum index mapping: s = 0..N_STATE-1 are next-state bits; s = N_STATE..N_SUM-1 are out bits 0..N_OUT-1.
- Term value: AND over literals with use=1 of (lit XOR pol). A term with no used literal evaluates to 0 (disabled), not 1.
- Sum value: OR of its N_TERMS terms.
- Shift: when cfg_en=1, each edge does cfg_sr <= {cfg_sr[CFG_W-2:0], cfg_data}. cfg_out = cfg_sr[CFG_W-1]. The first bit shifted in ends at index CFG_W-1 after CFG_W clocks.
- While cfg_en=1:
  - state and out_q are synchronously cleared to 0 every edge, regardless of en.
  - Mealy out still reflects the partially shifted plane; consumers must ignore out during configuration.
- Run: when cfg_en=0 and en=1, state <= next-state sums. If OUT_REG=1, out_q <= output sums evaluated on the pre-edge lit.
- Hold: when cfg_en=0 and en=0, state and out_q hold. cfg_sr holds whenever cfg_en=0.
- Output select: out = output sums when OUT_REG=0; out = out_q when OUT_REG=1.
- Latency:
  - state follows next-state logic with 1 cycle latency.
  - Mealy out has 0 latency from in.
  - Registered out has 1 cycle latency.
- Simultaneous events: cfg_en has priority over en. Asynchronous reset has priority over everything; reset mid-shift discards the partial configuration.
- Widths are fixed by the parameters; no arithmetic is performed.

Test Plan:
- Reset: hold rst_n=0 mid-operation with arbitrary in -> state=0, out=0, cfg_out=0 immediately, without waiting for a clock edge.
- Two-bit counter:
  - Configure next_s0 = ~s0, i.e. sum0 term0 uses l=2 with pol=1.
  - Configure next_s1 = s1&~s0 | ~s1&s0 using sum1 terms 0 and 1.
  - Hold en=1 for 5 clocks -> state sequence 0,1,2,3,0.
  - Then en=0 for 3 clocks -> state holds 0.
- Mealy output:
  - Configure out0 = in0 & s0, i.e. sum2 term0 uses l=0 and l=2, both pol=0.
  - With state=1, toggle in0 -> out0 follows in0 in the same cycle.
  - With OUT_REG=1 -> out0 changes one edge later.
- Empty term: all-zero configuration with in swept over all 4 values -> state and out stay 0.
- Chain passthrough: shift CFG_W+8 bits of pattern 0xA5 repeating -> cfg_out emits the first 8 shifted bits, in order, after exactly CFG_W clocks.
- Config priority: cfg_en=1 and en=1 while the counter is at state=2 -> state=0 on the next edge, and the counter does not advance during shifting.

Source files
------------

// File: rtl/pla_fsm.sv
// pla_fsm: field-programmable sum-of-products state machine whose plane is loaded through a serial chain
module pla_fsm #(
    parameter int N_IN    = 2,
    parameter int N_STATE = 2,
    parameter int N_OUT   = 2,
    parameter int N_TERMS = 3,
    parameter int OUT_REG = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_IN-1:0]    in,
    input  logic               cfg_en,
    input  logic               cfg_data,
    output logic               cfg_out,
    output logic [N_STATE-1:0] state,
    output logic [N_OUT-1:0]   out
);
    localparam int N_LIT = N_IN + N_STATE;
    localparam int N_SUM = N_STATE + N_OUT;
    localparam int CFG_W = N_SUM * N_TERMS * N_LIT * 2;

    logic [CFG_W-1:0] cfg_sr;
    logic [N_LIT-1:0] lit;
    logic [N_SUM-1:0] sums;
    logic [N_OUT-1:0] out_q;

    assign lit = {state, in};

    for (genvar s = 0; s < N_SUM; s++) begin : g_sum
        logic [N_TERMS-1:0] terms;
        for (genvar t = 0; t < N_TERMS; t++) begin : g_term
            logic [N_LIT-1:0] used;
            logic [N_LIT-1:0] hit;
            for (genvar l = 0; l < N_LIT; l++) begin : g_lit
                localparam int B = ((s * N_TERMS + t) * N_LIT + l) * 2;
                assign used[l] = cfg_sr[B];
                assign hit[l]  = ~cfg_sr[B] | (lit[l] ^ cfg_sr[B+1]);
            end
            // a term with no literal selected is disabled rather than constant true
            assign terms[t] = (|used) & (&hit);
        end
        assign sums[s] = |terms;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_sr <= '0;
            state  <= '0;
            out_q  <= '0;
        end else if (cfg_en) begin
            cfg_sr <= {cfg_sr[CFG_W-2:0], cfg_data};
            state  <= '0;
            out_q  <= '0;
        end else if (en) begin
            state <= sums[N_STATE-1:0];
            out_q <= sums[N_SUM-1:N_STATE];
        end
    end

    assign cfg_out = cfg_sr[CFG_W-1];
    assign out     = (OUT_REG != 0) ? out_q : sums[N_SUM-1:N_STATE];
endmodule

// File: tb/tb_pla_fsm.sv
// tb_pla_fsm: checks a Mealy and a registered-output pla_fsm side by side on shared stimulus
module tb_pla_fsm;
    localparam int N_IN = 2, N_STATE = 2, N_OUT = 2, N_TERMS = 3;
    localparam int N_LIT = N_IN + N_STATE;
    localparam int N_SUM = N_STATE + N_OUT;
    localparam int CFG_W = N_SUM * N_TERMS * N_LIT * 2;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_en = 1'b0, cfg_data = 1'b0;
    logic [N_IN-1:0] in = '0;
    logic cfg_out, cfg_out_r;
    logic [N_STATE-1:0] state, state_r;
    logic [N_OUT-1:0] out, out_r;
    int checks = 0, errors = 0;

    typedef struct {logic en; logic [1:0] in; logic [1:0] st; logic [1:0] mo; logic [1:0] ro;} vec_t;
    typedef struct {logic [1:0] st; logic [1:0] mo; logic [1:0] ro;} exp_t;
    vec_t vecs[10];
    exp_t sb[$];
    exp_t e;
    logic bits[$];
    logic [CFG_W-1:0] plane;
    logic [7:0] pat = 8'hA5;
    int nz;
    logic [1:0] first;

    pla_fsm #(.OUT_REG(0)) dut (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .cfg_en(cfg_en),
        .cfg_data(cfg_data), .cfg_out(cfg_out), .state(state), .out(out));
    pla_fsm #(.OUT_REG(1)) dut_r (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .cfg_en(cfg_en),
        .cfg_data(cfg_data), .cfg_out(cfg_out_r), .state(state_r), .out(out_r));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lit(input int s, input int t, input int l, input logic pol);
        plane[((s * N_TERMS + t) * N_LIT + l) * 2]     = 1'b1;
        plane[((s * N_TERMS + t) * N_LIT + l) * 2 + 1] = pol;
    endtask

    // shifts the whole plane MSB first; counts edges that left state non-zero
    task automatic load(input logic run, output int bad, output logic [1:0] st0);
        bad = 0;
        st0 = 2'bxx;
        for (int i = CFG_W - 1; i >= 0; i--) begin
            cfg_en = 1'b1;
            en = run;
            cfg_data = plane[i];
            tick;
            if (i == CFG_W - 1) st0 = state;
            if (state !== 2'd0 || state_r !== 2'd0) bad++;
        end
        cfg_en = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        // counter on state plus out0 = in0 & s0, out1 = ~in1; {en, in, state after, Mealy out after, registered out after}
        vecs[0] = '{1'b1, 2'b00, 2'd1, 2'd2, 2'd2};
        vecs[1] = '{1'b1, 2'b01, 2'd2, 2'd2, 2'd3};
        vecs[2] = '{1'b1, 2'b11, 2'd3, 2'd1, 2'd0};
        vecs[3] = '{1'b1, 2'b10, 2'd0, 2'd0, 2'd0};
        vecs[4] = '{1'b0, 2'b01, 2'd0, 2'd2, 2'd0};
        vecs[5] = '{1'b0, 2'b11, 2'd0, 2'd0, 2'd0};
        vecs[6] = '{1'b0, 2'b00, 2'd0, 2'd2, 2'd0};
        vecs[7] = '{1'b1, 2'b01, 2'd1, 2'd3, 2'd2};
        vecs[8] = '{1'b0, 2'b00, 2'd1, 2'd2, 2'd2};
        vecs[9] = '{1'b1, 2'b11, 2'd2, 2'd0, 2'd1};

        in = 2'b10;
        #3;
        check("reset_state", state, 0);
        check("reset_out", out, 0);
        check("reset_cfg_out", cfg_out, 0);
        check("reset_state_r", state_r, 0);
        check("reset_out_r", out_r, 0);
        #4 rst_n = 1'b1;

        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in = i[1:0];
            #1;
            check("empty_out", out, 0);
            tick;
            check("empty_state", state, 0);
            check("empty_out_r", out_r, 0);
        end

        en = 1'b0;
        cfg_en = 1'b1;
        for (int k = 1; k <= CFG_W + 8; k++) begin
            cfg_data = pat[7 - ((k - 1) % 8)];
            bits.push_back(cfg_data);
            tick;
            if (k == CFG_W - 1) check("chain_early", cfg_out, 0);
            if (k >= CFG_W) check("chain_bit", cfg_out, bits.pop_front());
        end
        cfg_en = 1'b0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;

        plane = '0;
        set_lit(0, 0, 2, 1'b1);
        set_lit(1, 0, 3, 1'b0);
        set_lit(1, 0, 2, 1'b1);
        set_lit(1, 1, 3, 1'b1);
        set_lit(1, 1, 2, 1'b0);
        set_lit(2, 0, 0, 1'b0);
        set_lit(2, 0, 2, 1'b0);
        set_lit(3, 0, 1, 1'b1);
        load(1'b0, nz, first);
        check("load_state", state, 0);

        foreach (vecs[i]) begin
            en = vecs[i].en;
            in = vecs[i].in;
            sb.push_back('{vecs[i].st, vecs[i].mo, vecs[i].ro});
            tick;
            e = sb.pop_front();
            check("vec_state", state, e.st);
            check("vec_state_r", state_r, e.st);
            check("vec_mealy", out, e.mo);
            check("vec_reg_out", out_r, e.ro);
        end

        load(1'b1, nz, first);
        check("prio_first_edge", first, 0);
        check("prio_no_advance", nz, 0);

        en = 1'b1;
        in = 2'b00;
        tick;
        check("post_cfg_state", state, 1);
        check("post_cfg_out_r", out_r, 2);
        en = 1'b0;
        in = 2'b01;
        #1;
        check("mealy_rise", out[0], 1);
        check("reg_no_change", out_r, 2);
        in = 2'b00;
        #1;
        check("mealy_fall", out[0], 0);
        in = 2'b01;
        en = 1'b1;
        #1;
        check("reg_pre_edge", out_r, 2);
        tick;
        check("reg_post_edge", out_r, 3);
        check("reg_state", state, 2);

        in = 2'b11;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_out", out, 0);
        check("async_cfg_out", cfg_out, 0);
        check("async_state_r", state_r, 0);
        check("async_out_r", out_r, 0);
        #5 rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
